// File: rtl/vga_pkg.sv
// vga_pkg: shared parser state encoding, command/ack byte constants and hex decode
// Ports: none (package). Imported by the sequencer, its interface and the commit block.
package vga_pkg;
   typedef enum logic [2:0] {IDLE, P_X, P_Y, C_R, C_G, C_B} state_t;
   typedef struct packed {
      logic       ok;
      logic [3:0] nib;
   } hex_t;
   localparam logic [7:0] CMD_POS = 8'h50;
   localparam logic [7:0] CMD_COL = 8'h43;
   localparam logic [7:0] ACK_OK  = 8'h4B;
   localparam logic [7:0] ACK_ERR = 8'h45;
   // Uppercase-only hex: '0'-'9' and 'A'-'F'; bit 6 separates the letter range.
   function automatic hex_t hex_decode(input logic [7:0] b);
      hex_t h;
      h.ok  = (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46);
      h.nib = b[6] ? b[3:0] + 4'd9 : b[3:0];
      return h;
   endfunction
endpackage

// File: rtl/vga_cmd_sequencer_if.sv
// vga_cmd_sequencer_if: byte-stream, vsync and cursor/colour signals of the command sequencer
// Signals: rx_data/rx_valid/vsync toward the sequencer; position_x/y, color, pending,
// frame_commit, cmd_err from it; tx_data/tx_valid/tx_ready only with VGA_CMD_ACK_EN.
// Modports: master (byte source / display side), slave (the sequencer).
interface vga_cmd_sequencer_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        vsync;
   logic [7:0]  position_x;
   logic [7:0]  position_y;
   logic [11:0] color;
   logic        pending;
   logic        frame_commit;
   logic        cmd_err;
`ifdef VGA_CMD_ACK_EN
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   modport master (output rx_data, rx_valid, vsync, tx_ready,
                   input position_x, position_y, color, pending, frame_commit, cmd_err, tx_data, tx_valid);
   modport slave  (input rx_data, rx_valid, vsync, tx_ready,
                   output position_x, position_y, color, pending, frame_commit, cmd_err, tx_data, tx_valid);
`else
   modport master (output rx_data, rx_valid, vsync,
                   input position_x, position_y, color, pending, frame_commit, cmd_err);
   modport slave  (input rx_data, rx_valid, vsync,
                   output position_x, position_y, color, pending, frame_commit, cmd_err);
`endif
endinterface

// File: rtl/vga_cmd_commit.sv
// vga_cmd_commit: shadow/live cursor registers, committed on the vsync rising edge
// Ports: CLK, reset_n (async, active low); vsync; wr_pos/wr_x/wr_y and wr_col/wr_color
// write the shadow; position_x/y, color (live), pending, frame_commit out.
module vga_cmd_commit (
   input  logic        CLK,
   input  logic        reset_n,
   input  logic        vsync,
   input  logic        wr_pos,
   input  logic        wr_col,
   input  logic [3:0]  wr_x,
   input  logic [3:0]  wr_y,
   input  logic [11:0] wr_color,
   output logic [7:0]  position_x,
   output logic [7:0]  position_y,
   output logic [11:0] color,
   output logic        pending,
   output logic        frame_commit
);
   logic [7:0]  sh_x, sh_y;
   logic [11:0] sh_c;
   logic        vs_q, rise;
   assign rise = vsync & ~vs_q;
   // A write landing with a rise commits the old shadow and keeps pending for the next frame.
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         vs_q         <= 1'b0;
         sh_x         <= '0;
         sh_y         <= '0;
         sh_c         <= '0;
         position_x   <= '0;
         position_y   <= '0;
         color        <= '0;
         pending      <= 1'b0;
         frame_commit <= 1'b0;
      end else begin
         vs_q <= vsync;
         if (wr_pos) begin
            sh_x <= {4'd0, wr_x};
            sh_y <= {4'd0, wr_y};
         end
         if (wr_col) sh_c <= wr_color;
         if (rise) begin
            position_x <= sh_x;
            position_y <= sh_y;
            color      <= sh_c;
         end
         frame_commit <= rise & pending;
         pending      <= wr_pos | wr_col | (pending & ~rise);
      end
endmodule

// File: rtl/vga_cmd_sequencer.sv
// vga_cmd_sequencer: parses UART 'P'/'C' commands into a shadow cursor and commits at retrace
// Ports: CLK, reset_n (async, active low), bus (vga_cmd_sequencer_if.slave): rx_data, rx_valid,
// vsync in; position_x/y, color, pending, frame_commit, cmd_err out; with macro
// VGA_CMD_ACK_EN also tx_data/tx_valid out and tx_ready in ('K' ok / 'E' error acks).
module vga_cmd_sequencer
   import vga_pkg::*;
#(
   parameter int X_MAX       = 15,
   parameter int Y_MAX       = 15,
   parameter int TIMEOUT_CYC = 1000000
) (
   input logic                CLK,
   input logic                reset_n,
   vga_cmd_sequencer_if.slave bus
);
   state_t      state, state_nx;
   logic [3:0]  arg_a, arg_b;
   logic [31:0] idle_cnt;
   hex_t        hx;
   logic        good, timeout, err, wr_pos, wr_col;
   assign hx   = hex_decode(bus.rx_data);
   assign good = hx.ok && (state == P_X ? int'(hx.nib) <= X_MAX :
                           state == P_Y ? int'(hx.nib) <= Y_MAX : 1'b1);
   // Only a silent cycle can expire: a byte in the expiry cycle is parsed normally.
   assign timeout = TIMEOUT_CYC != 0 && state != IDLE && !bus.rx_valid &&
                    idle_cnt == 32'(TIMEOUT_CYC - 1);
   always_comb begin
      state_nx = state;
      err      = timeout;
      wr_pos   = 1'b0;
      wr_col   = 1'b0;
      if (timeout) state_nx = IDLE;
      else if (bus.rx_valid && state == IDLE)
         state_nx = bus.rx_data == CMD_POS ? P_X : bus.rx_data == CMD_COL ? C_R : IDLE;
      else if (bus.rx_valid) begin
         err      = !good;
         wr_pos   = good && state == P_Y;
         wr_col   = good && state == C_B;
         state_nx = !good ? IDLE : state == P_X ? P_Y : state == C_R ? C_G : state == C_G ? C_B : IDLE;
      end
   end
   // arg_a holds X (position) or R (colour); arg_b holds G.
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         state       <= IDLE;
         arg_a       <= '0;
         arg_b       <= '0;
         idle_cnt    <= '0;
         bus.cmd_err <= 1'b0;
      end else begin
         state       <= state_nx;
         bus.cmd_err <= err;
         idle_cnt    <= (state == IDLE || bus.rx_valid) ? '0 : idle_cnt + 1;
         if (bus.rx_valid && (state == P_X || state == C_R)) arg_a <= hx.nib;
         if (bus.rx_valid && state == C_G) arg_b <= hx.nib;
      end
   vga_cmd_commit u_commit (
      .CLK          (CLK),
      .reset_n      (reset_n),
      .vsync        (bus.vsync),
      .wr_pos       (wr_pos),
      .wr_col       (wr_col),
      .wr_x         (arg_a),
      .wr_y         (hx.nib),
      .wr_color     ({arg_a, arg_b, hx.nib}),
      .position_x   (bus.position_x),
      .position_y   (bus.position_y),
      .color        (bus.color),
      .pending      (bus.pending),
      .frame_commit (bus.frame_commit)
   );
`ifdef VGA_CMD_ACK_EN
   // Single ack slot: a newer ack replaces an unsent one.
   always_ff @(posedge CLK or negedge reset_n)
      if (!reset_n) begin
         bus.tx_valid <= 1'b0;
         bus.tx_data  <= '0;
      end else if (wr_pos || wr_col || err) begin
         bus.tx_valid <= 1'b1;
         bus.tx_data  <= err ? ACK_ERR : ACK_OK;
      end else if (bus.tx_ready) bus.tx_valid <= 1'b0;
`endif
endmodule

// File: tb/tb_vga_cmd_sequencer.sv
// tb_vga_cmd_sequencer: randomized + directed scoreboard bench for vga_cmd_sequencer
// Ports: none. Honours VGA_CMD_ACK_EN to also check the TX acknowledge side.
module tb_vga_cmd_sequencer;
   localparam int XM = 12, YM = 9, TMO = 16;
   logic CLK = 1'b0, reset_n = 1'b0;
   always #5 CLK = ~CLK;
   vga_cmd_sequencer_if bus ();
   vga_cmd_sequencer #(.X_MAX(XM), .Y_MAX(YM), .TIMEOUT_CYC(TMO)) dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .bus     (bus)
   );
   typedef struct {
      int          cyc;
      bit          p;
      logic [7:0]  x, y;
      logic [11:0] c;
      bit          tv;
      logic [7:0]  td;
   } st_t;
   typedef struct {
      int          cyc;
      logic [7:0]  x, y;
      logic [11:0] c;
   } ev_t;
   st_t sq[$];
   ev_t cq[$];
   int  eq[$];
   int  cyc = 0, checks = 0, errors = 0;
   logic [7:0]  op, sx, sy, lx, ly, td;
   logic [11:0] sc, lc;
   int  args[$];
   int  idle;
   bit  pend, vs_prev, vs_lvl, rdy_lvl, tv;
   logic [7:0] pool [0:11] = '{8'h50, 8'h43, 8'h30, 8'h37, 8'h39, 8'h41,
                               8'h46, 8'h42, 8'h61, 8'h67, 8'h0D, 8'h35};
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic int hexval(input logic [7:0] d);
      string h;
      h = "0123456789ABCDEF";
      for (int i = 0; i < 16; i++) if (h[i] == d) return i;
      return -1;
   endfunction

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, got, exp);
      end
   endtask

   task automatic model_clear();
      op = 0; args.delete(); idle = 0;
      sx = 0; sy = 0; sc = 0; lx = 0; ly = 0; lc = 0;
      pend = 0; vs_prev = 0; vs_lvl = 0; tv = 0; td = 0;
   endtask

   // One clock of stimulus; the model predicts what the DUT shows one cycle later.
   task automatic step(input bit v, input logic [7:0] d);
      bit err, wr, rise;
      int n, lim;
      logic [7:0] nsx, nsy;
      logic [11:0] nsc;
      err = 0; wr = 0; nsx = sx; nsy = sy; nsc = sc;
      @(negedge CLK);
      bus.rx_valid = v;
      bus.rx_data  = d;
      bus.vsync    = vs_lvl;
`ifdef VGA_CMD_ACK_EN
      bus.tx_ready = rdy_lvl;
`endif
      rise = vs_lvl && !vs_prev;
      if (v) begin
         idle = 0;
         if (op == 0) op = (d == 8'h50 || d == 8'h43) ? d : 8'h00;
         else begin
            n   = hexval(d);
            lim = op == 8'h43 ? 15 : args.size() == 0 ? XM : YM;
            if (n < 0 || n > lim) begin
               err = 1; op = 0; args.delete();
            end else begin
               args.push_back(n);
               if (op == 8'h50 && args.size() == 2) begin
                  wr = 1; nsx = 8'(args[0]); nsy = 8'(args[1]);
               end
               if (op == 8'h43 && args.size() == 3) begin
                  wr = 1; nsc = 12'(args[0] * 256 + args[1] * 16 + args[2]);
               end
               if (wr) begin op = 0; args.delete(); end
            end
         end
      end else if (op != 0) begin
         idle++;
         if (idle == TMO) begin err = 1; op = 0; args.delete(); end
      end
      if (rise) begin
         lx = sx; ly = sy; lc = sc;
         if (pend) cq.push_back('{cyc + 1, sx, sy, sc});
      end
      pend = wr || (pend && !rise);
      sx = nsx; sy = nsy; sc = nsc;
      if (wr || err) begin
         tv = 1; td = wr ? 8'h4B : 8'h45;
      end else if (rdy_lvl) tv = 0;
      sq.push_back('{cyc + 1, pend, lx, ly, lc, tv, td});
      if (err) eq.push_back(cyc + 1);
      vs_prev = vs_lvl;
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic vrise();
      vs_lvl = 1; idle_n(3);
      vs_lvl = 0; idle_n(2);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #1;
      chk("queues drained before reset", 32'(sq.size() + cq.size() + eq.size()), 0);
      reset_n = 0;
      bus.rx_valid = 0; bus.vsync = 0;
      #1;
      chk("reset position_x", bus.position_x, 0);
      chk("reset position_y", bus.position_y, 0);
      chk("reset color", bus.color, 0);
      chk("reset pending", bus.pending, 0);
      chk("reset frame_commit", bus.frame_commit, 0);
      chk("reset cmd_err", bus.cmd_err, 0);
`ifdef VGA_CMD_ACK_EN
      chk("reset tx_valid", bus.tx_valid, 0);
      chk("reset tx_data", bus.tx_data, 0);
`endif
      model_clear();
      @(negedge CLK);
      reset_n = 1;
   endtask

   always @(negedge CLK) if (reset_n) begin
      st_t s;
      ev_t e;
      if (sq.size() != 0 && sq[0].cyc == cyc) begin
         s = sq.pop_front();
         chk("pending", bus.pending, s.p);
         chk("position_x", bus.position_x, s.x);
         chk("position_y", bus.position_y, s.y);
         chk("color", bus.color, s.c);
`ifdef VGA_CMD_ACK_EN
         chk("tx_valid", bus.tx_valid, s.tv);
         if (s.tv) chk("tx_data", bus.tx_data, s.td);
`endif
      end
      if (bus.frame_commit) begin
         if (cq.size() != 0 && cq[0].cyc == cyc) begin
            e = cq.pop_front();
            chk("commit position_x", bus.position_x, e.x);
            chk("commit position_y", bus.position_y, e.y);
            chk("commit color", bus.color, e.c);
         end else chk("frame_commit unexpected", 1, 0);
      end
      while (cq.size() != 0 && cq[0].cyc <= cyc) begin
         chk("frame_commit missing", 0, 1);
         void'(cq.pop_front());
      end
      if (bus.cmd_err) begin
         if (eq.size() != 0 && eq[0] == cyc) begin
            checks++;
            void'(eq.pop_front());
         end else chk("cmd_err unexpected", 1, 0);
      end
      while (eq.size() != 0 && eq[0] <= cyc) begin
         chk("cmd_err missing", 0, 1);
         void'(eq.pop_front());
      end
   end

   initial begin
      bus.rx_valid = 0; bus.rx_data = 0; bus.vsync = 0;
`ifdef VGA_CMD_ACK_EN
      bus.tx_ready = 0;
`endif
      rdy_lvl = 1;
      model_clear();
      do_reset();
      send("P35"); idle_n(3); vrise();
      send("CF0A"); vrise();
      send("P3g"); send("P12"); vrise();
      send("PD"); send("P3A"); send("Ca"); idle_n(2);
      send("C1"); idle_n(18); send("2"); idle_n(2);
      send("P4"); vs_lvl = 1; step(1'b1, 8'h37); idle_n(2);
      vs_lvl = 0; idle_n(2); vrise();
      send("P1"); send("C123"); send("P98"); vrise();
      rdy_lvl = 0; send("P11"); idle_n(4);
      rdy_lvl = 1; idle_n(2); rdy_lvl = 0;
      send("Q"); send("P9"); idle_n(2);
      send("C7"); do_reset();
      send("2"); send("P12"); vrise();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) vs_lvl = !vs_lvl;
         rdy_lvl = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 149) == 0) idle_n(TMO + 2);
         else if ($urandom_range(0, 9) < 6)
            step(1'b1, $urandom_range(0, 9) < 8 ? pool[$urandom_range(0, 11)] : 8'($urandom));
         else step(1'b0, 8'h00);
      end
      vs_lvl = 0; idle_n(4); vrise(); idle_n(4);
      @(negedge CLK);
      #1;
      chk("expectations left over", 32'(sq.size() + cq.size() + eq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
